status_event_capture: RTL and testbench

//  Conditioning stage directly upstream of the status register. Synchronizes raw async

---
 rtl/status_capture_pkg.sv | 25 ++
 rtl/status_capture_bit.sv | 68 ++++++
 rtl/status_event_capture.sv | 135 +++++++++++++
 tb/tb_status_event_capture.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/status_capture_pkg.sv
// rtl/status_capture_pkg.sv - shared types and widths for the status event capture block
package status_capture_pkg;

    localparam int STS_W      = 8;
    localparam int FILT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ACK
    } clr_state_t;

    // Bit mask with the lowest n bits set; bits at or above n are inactive inputs
    function automatic logic [STS_W-1:0] valid_mask(input int n);
        logic [STS_W-1:0] m;
        m = '0;
        for (int i = 0; i < STS_W; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/status_capture_bit.sv
// rtl/status_capture_bit.sv - per-bit synchronizer, optional glitch filter (STATUS_CAPTURE_GLITCH_FILTER_EN) and edge detector
module status_capture_bit
    import status_capture_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 3,
    parameter logic EDGE_POL    = 1'b0
)(
    input  logic clock,
    input  logic reset_n,
    input  logic event_in,
    output logic f,
    output logic edge_det
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   prev_q;

    // Shift the raw asynchronous net through the synchronizer chain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef STATUS_CAPTURE_GLITCH_FILTER_EN
    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILTER_LEN - 1);

    logic [FILT_CNT_W-1:0] cnt_q;
    logic                  filt_q;

    // Accept a new level only after FILTER_LEN consecutive samples disagree with the held one
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (s == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_q <= s;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign f = filt_q;
`else
    assign f = s;
`endif

    // Remember last cycle's conditioned level so transitions can be seen
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= f;
        end
    end

    assign edge_det = EDGE_POL ? (~f & prev_q) : (f & ~prev_q);

endmodule

// File: rtl/status_event_capture.sv
// rtl/status_event_capture.sv - sticky/level status capture with overflow, clear handshake and interrupt; filter via STATUS_CAPTURE_GLITCH_FILTER_EN
module status_event_capture
    import status_capture_pkg::*;
#(
    parameter int               NUM_INPUTS    = 8,
    parameter logic [STS_W-1:0] STICKY_MASK   = 8'h00,
    parameter logic [STS_W-1:0] EDGE_POLARITY = 8'h00,
    parameter int               SYNC_STAGES   = 2,
    parameter int               FILTER_LEN    = 3
)(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [STS_W-1:0] event_in,
    input  logic             clr_req,
    input  logic [STS_W-1:0] clr_mask,
    output logic             clr_ack,
    output logic [STS_W-1:0] status,
    output logic [STS_W-1:0] overflow,
    output logic             intr
);

    localparam logic [STS_W-1:0] VALID      = valid_mask(NUM_INPUTS);
    localparam logic [STS_W-1:0] STICKY_EFF = STICKY_MASK & VALID;
    localparam logic [STS_W-1:0] LEVEL_EFF  = ~STICKY_MASK & VALID;

    logic [STS_W-1:0] f_bus;
    logic [STS_W-1:0] edge_bus;
    logic [STS_W-1:0] sticky_q;
    logic [STS_W-1:0] ovf_q;
    logic [STS_W-1:0] mreg_q;
    logic [STS_W-1:0] clr_bits;
    logic             intr_q;
    logic             clear_now;
    clr_state_t       state_q;
    clr_state_t       state_d;

    for (genvar i = 0; i < STS_W; i++) begin : g_bit
        if (i < NUM_INPUTS) begin : g_active
            status_capture_bit #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_LEN  (FILTER_LEN),
                .EDGE_POL    (EDGE_POLARITY[i])
            ) u_bit (
                .clock    (clock),
                .reset_n  (reset_n),
                .event_in (event_in[i]),
                .f        (f_bus[i]),
                .edge_det (edge_bus[i])
            );
        end else begin : g_tie
            assign f_bus[i]    = 1'b0;
            assign edge_bus[i] = 1'b0;
        end
    end

    // Clear handshake state register; reset aborts any clear in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear handshake sequencing and ack decode
    always_comb begin
        state_d   = state_q;
        clr_ack   = 1'b0;
        clear_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clear_now = 1'b1;
                state_d   = ACK;
            end
            ACK: begin
                clr_ack = 1'b1;
                if (!clr_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the firmware mask when a request is accepted so later wiggles cannot matter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mreg_q <= '0;
        end else if (state_q == IDLE && clr_req) begin
            mreg_q <= clr_mask;
        end
    end

    // Level-mode bits are never cleared; only sticky bits respond to the mask
    assign clr_bits = clear_now ? (mreg_q & STICKY_EFF) : '0;

    // Sticky flags: a new edge wins over a clear in the same cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (edge_bus & STICKY_EFF) | (sticky_q & ~clr_bits);
        end
    end

    // Overflow: an edge landing on an already-set sticky flag; clear always empties it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q | (edge_bus & sticky_q & STICKY_EFF)) & ~clr_bits;
        end
    end

    // Interrupt request trails the sticky status by one cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= |(sticky_q & STICKY_EFF);
        end
    end

    assign status   = (sticky_q & STICKY_EFF) | (f_bus & LEVEL_EFF);
    assign overflow = ovf_q;
    assign intr     = intr_q;

endmodule

// File: tb/tb_status_event_capture.sv
// tb/tb_status_event_capture.sv - self-checking bench for status_event_capture
module tb_status_event_capture;

    localparam int         NI    = 6;
    localparam logic [7:0] SM    = 8'h37;
    localparam logic [7:0] EP    = 8'h04;
    localparam int         SS    = 2;
    localparam int         FL    = 3;
    localparam logic [7:0] VALID = 8'h3F;
    localparam int         HN    = 4096;
`ifdef STATUS_CAPTURE_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] event_in = 8'h00;
    logic       clr_req  = 1'b0;
    logic [7:0] clr_mask = 8'h00;
    logic       clr_ack;
    logic [7:0] status;
    logic [7:0] overflow;
    logic       intr;

    int checks = 0;
    int errors = 0;

    status_event_capture #(
        .NUM_INPUTS    (NI),
        .STICKY_MASK   (SM),
        .EDGE_POLARITY (EP),
        .SYNC_STAGES   (SS),
        .FILTER_LEN    (FL)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .event_in (event_in),
        .clr_req  (clr_req),
        .clr_mask (clr_mask),
        .clr_ack  (clr_ack),
        .status   (status),
        .overflow (overflow),
        .intr     (intr)
    );

    always #5 clock = ~clock;

    // Reference model: histories of raw samples and conditioned levels indexed by edge count
    logic [7:0] e_h [HN];
    logic [7:0] f_h [HN];
    int         k;
    logic [7:0] m_sticky, m_ovf, m_status, m_mask;
    logic       m_intr, m_ack;
    int         m_phase;

    function automatic logic [7:0] get_e(input int i);
        return (i < 0) ? 8'h00 : e_h[i];
    endfunction

    function automatic logic [7:0] get_s(input int i);
        return get_e(i - SS + 1);
    endfunction

    function automatic logic [7:0] get_f(input int i);
        return (i < 0) ? 8'h00 : f_h[i];
    endfunction

    task automatic model_reset();
        k        = 0;
        m_sticky = 8'h00;
        m_ovf    = 8'h00;
        m_status = 8'h00;
        m_mask   = 8'h00;
        m_intr   = 1'b0;
        m_ack    = 1'b0;
        m_phase  = 0;
    endtask

    task automatic model_step(input logic [7:0] ev, input logic req, input logic [7:0] msk);
        logic [7:0] fk, f1, f2, diff, evb, clr;
        e_h[k] = ev;
        f1 = get_f(k - 1);
        if (!FILT) begin
            fk = get_s(k);
        end else begin
            diff = 8'hFF;
            for (int j = 1; j <= FL; j++) diff &= get_s(k - j) ^ f1;
            fk = f1 ^ diff;
        end
        f_h[k] = fk;
        f2  = get_f(k - 2);
        evb = (((f1 & ~f2) & ~EP) | ((~f1 & f2) & EP)) & SM & VALID;
        clr = (m_phase == 1) ? (m_mask & SM & VALID) : 8'h00;
        m_intr   = |(m_sticky & SM & VALID);
        m_ovf    = (m_ovf | (evb & m_sticky)) & ~clr;
        m_sticky = evb | (m_sticky & ~clr);
        case (m_phase)
            0: if (req) begin m_phase = 1; m_mask = msk; end
            1: m_phase = 2;
            default: if (!req) m_phase = 0;
        endcase
        m_ack    = (m_phase == 2);
        m_status = ((m_sticky & SM) | (fk & ~SM)) & VALID;
        k++;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(event_in, clr_req, clr_mask);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] ev;
        logic       req;
        logic [7:0] mask;
        logic [7:0] st;
        logic [7:0] ov;
        logic       it;
        logic       ak;
    } vec_t;

    vec_t tbl [26];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{8'h01, 1'b0, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[6]  = '{8'h00, 1'b0, 8'h00, 8'h01, 8'h01, 1'b1, 1'b0};
        tbl[7]  = '{8'h08, 1'b0, 8'h00, 8'h01, 8'h01, 1'b1, 1'b0};
        tbl[8]  = '{8'h08, 1'b0, 8'h00, 8'h09, 8'h01, 1'b1, 1'b0};
        tbl[9]  = '{8'h08, 1'b1, 8'h09, 8'h09, 8'h01, 1'b1, 1'b0};
        tbl[10] = '{8'h08, 1'b1, 8'h09, 8'h08, 8'h00, 1'b1, 1'b1};
        tbl[11] = '{8'h08, 1'b0, 8'h00, 8'h08, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{8'h00, 1'b0, 8'h00, 8'h08, 8'h00, 1'b0, 1'b0};
        tbl[13] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[14] = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[15] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[16] = '{8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[17] = '{8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[18] = '{8'h01, 1'b0, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[19] = '{8'h00, 1'b1, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[20] = '{8'h00, 1'b1, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1};
        tbl[21] = '{8'h00, 1'b1, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1};
        tbl[22] = '{8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[23] = '{8'h00, 1'b1, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[24] = '{8'h00, 1'b1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[25] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

        model_reset();
        #2;
        chk("reset_status", status, 8'h00);
        chk("reset_overflow", overflow, 8'h00);
        chk("reset_intr", {7'd0, intr}, 8'h00);
        chk("reset_ack", {7'd0, clr_ack}, 8'h00);
        release_reset();

`ifndef STATUS_CAPTURE_GLITCH_FILTER_EN
        // Directed table: sticky capture, overflow, clear, level bit, edge during CLEAR
        for (int i = 0; i < 26; i++) begin
            event_in = tbl[i].ev;
            clr_req  = tbl[i].req;
            clr_mask = tbl[i].mask;
            tick();
            chk($sformatf("row%0d_status", i), status, tbl[i].st);
            chk($sformatf("row%0d_overflow", i), overflow, tbl[i].ov);
            chk($sformatf("row%0d_intr", i), {7'd0, intr}, {7'd0, tbl[i].it});
            chk($sformatf("row%0d_ack", i), {7'd0, clr_ack}, {7'd0, tbl[i].ak});
        end
`else
        // Glitch filter: short pulse dropped, 4-cycle pulse lands SYNC_STAGES+FILTER_LEN+1 cycles later
        event_in = 8'h01;
        repeat (2) tick();
        event_in = 8'h00;
        repeat (8) tick();
        chk("filt_short_pulse", status & 8'h01, 8'h00);
        for (int n = 0; n < 6; n++) begin
            event_in = (n < 4) ? 8'h01 : 8'h00;
            tick();
            if (n == 4) chk("filt_long_early", status & 8'h01, 8'h00);
            if (n == 5) chk("filt_long_set", status & 8'h01, 8'h01);
        end
        event_in = 8'h00;
        repeat (6) tick();
`endif

        // Reset while the clear FSM is in CLEAR, then in ACK
        event_in = 8'h01;
        repeat (5) tick();
        event_in = 8'h00;
        repeat (6) tick();
        chk("rst_pre_status", status & 8'h01, 8'h01);
        clr_mask = 8'h01;
        clr_req  = 1'b1;
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_clear_status", status, 8'h00);
        chk("rst_clear_overflow", overflow, 8'h00);
        chk("rst_clear_intr", {7'd0, intr}, 8'h00);
        chk("rst_clear_ack", {7'd0, clr_ack}, 8'h00);
        clr_req = 1'b0;
        repeat (2) @(posedge clock);
        release_reset();
        clr_req = 1'b1;
        tick();
        chk("post_rst_ack_first", {7'd0, clr_ack}, 8'h00);
        tick();
        chk("post_rst_ack_second", {7'd0, clr_ack}, 8'h01);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ack_ack", {7'd0, clr_ack}, 8'h00);
        clr_req = 1'b0;
        release_reset();
        tick();
        chk("post_rst2_ack", {7'd0, clr_ack}, 8'h00);

        // Randomized traffic against the reference model
        reset_n = 1'b0;
        event_in = 8'h00;
        clr_mask = 8'h00;
        repeat (2) @(posedge clock);
        release_reset();
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, FILT ? 5 : 3) == 0) event_in[b] = ~event_in[b];
            end
            if (clr_req && m_ack) begin
                clr_req  = 1'b0;
                clr_mask = 8'h00;
            end else if (!clr_req && m_phase == 0 && $urandom_range(0, 11) == 0) begin
                clr_req  = 1'b1;
                clr_mask = 8'($urandom);
            end
            tick();
            chk($sformatf("rnd%0d_status", n), status, m_status);
            chk($sformatf("rnd%0d_overflow", n), overflow, m_ovf);
            chk($sformatf("rnd%0d_intr", n), {7'd0, intr}, {7'd0, m_intr});
            chk($sformatf("rnd%0d_ack", n), {7'd0, clr_ack}, {7'd0, m_ack});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
